// File: rtl/counter_checker.sv
// counter_checker: receive-side checker for an enable-gated up-counter with
// carry-out. Seeds on the first sample, locks after SYNC_CNT more correct
// samples, then checks every enabled sample for +1 progression and carry.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   enable       sample qualifier for din/cin
//   din, cin     sampled counter value and carry-out
//   clear        synchronous clear of err_count (wins over an increment)
//   locked       1 while the checker is in LOCKED
//   err_pulse    one-cycle strobe after a mismatching sample while locked
//   wrap_pulse   one-cycle strobe after a correct max->0 wrap while locked
//   err_count    saturating error count since reset/clear
//   expected     value the checker expects on the next sample
module counter_checker #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned SYNC_CNT = 2,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] din,
  input  logic             cin,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic             wrap_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] expected
);

  // Good-sample counter must hold values 0..SYNC_CNT.
  localparam int unsigned GOOD_W = (SYNC_CNT < 1) ? 1 : $clog2(SYNC_CNT + 1);

  localparam logic [WIDTH-1:0]  VAL_MAX  = '1;
  localparam logic [ERR_W-1:0]  ERR_MAX  = '1;
  localparam logic [GOOD_W-1:0] GOOD_TGT = GOOD_W'(SYNC_CNT);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    SYNCING  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [GOOD_W-1:0]  good_q, good_d;
  logic [WIDTH-1:0]   exp_d;
  logic [ERR_W-1:0]   err_cnt_d;
  logic               err_d;
  logic               wrap_d;
  logic               err_inc;

  logic               din_max;
  logic               match;
  logic [WIDTH-1:0]   din_next;
  logic [GOOD_W-1:0]  good_inc;

  // Sample classification; carry must agree with the all-ones value.
  assign din_max  = (din == VAL_MAX);
  assign match    = (din == expected) && (cin == din_max);
  assign din_next = din + WIDTH'(1);
  assign good_inc = good_q + GOOD_W'(1);

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    exp_d   = expected;
    err_d   = 1'b0;
    wrap_d  = 1'b0;
    err_inc = 1'b0;

    if (enable) begin
      case (state_q)
        UNLOCKED: begin
          // Seed sample: adopt the stream without checking it.
          exp_d   = din_next;
          good_d  = '0;
          state_d = SYNCING;
        end
        SYNCING: begin
          exp_d = din_next;
          if (match) begin
            good_d = good_inc;
            if (good_inc == GOOD_TGT) begin
              state_d = LOCKED;
            end
          end else begin
            // Re-seed silently; errors are only counted once locked.
            good_d = '0;
          end
        end
        LOCKED: begin
          exp_d = din_next;
          if (match) begin
            wrap_d = (din == '0);
          end else begin
            err_d   = 1'b1;
            err_inc = 1'b1;
            good_d  = '0;
            state_d = SYNCING;
          end
        end
        default: begin
          state_d = UNLOCKED;
          good_d  = '0;
        end
      endcase
    end

    // Clear wins over a same-cycle increment; count saturates.
    if (clear) begin
      err_cnt_d = '0;
    end else if (err_inc && (err_count != ERR_MAX)) begin
      err_cnt_d = err_count + ERR_W'(1);
    end else begin
      err_cnt_d = err_count;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= UNLOCKED;
      good_q     <= '0;
      expected   <= '0;
      err_count  <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      state_q    <= state_d;
      good_q     <= good_d;
      expected   <= exp_d;
      err_count  <= err_cnt_d;
      locked     <= (state_d == LOCKED);
      err_pulse  <= err_d;
      wrap_pulse <= wrap_d;
    end
  end

endmodule

// File: tb/tb_counter_checker.sv
// Directed self-checking bench for counter_checker (WIDTH=8, SYNC_CNT=2, ERR_W=8).
module tb_counter_checker;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] din;
  logic       cin;
  logic       clear;
  logic       locked;
  logic       err_pulse;
  logic       wrap_pulse;
  logic [7:0] err_count;
  logic [7:0] expected;

  int checks = 0;
  int errors = 0;

  counter_checker #(
    .WIDTH    (8),
    .SYNC_CNT (2),
    .ERR_W    (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .din        (din),
    .cin        (cin),
    .clear      (clear),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .wrap_pulse (wrap_pulse),
    .err_count  (err_count),
    .expected   (expected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic lk, input logic ep, input logic wp,
                         input logic [7:0] cnt, input logic [7:0] ex);
    chk({tag, ".locked"},     32'(locked),     32'(lk));
    chk({tag, ".err_pulse"},  32'(err_pulse),  32'(ep));
    chk({tag, ".wrap_pulse"}, 32'(wrap_pulse), 32'(wp));
    chk({tag, ".err_count"},  32'(err_count),  32'(cnt));
    chk({tag, ".expected"},   32'(expected),   32'(ex));
  endtask

  // Apply one cycle of inputs at the falling edge; outputs settle 1ns after the rising edge.
  task automatic step(input logic en, input logic [7:0] d, input logic c, input logic clr);
    @(negedge clk);
    enable = en;
    din    = d;
    cin    = c;
    clear  = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    din    = '0;
    cin    = 1'b0;
    clear  = 1'b0;
    #23;
    chk_all("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Seed 5, then 6 and 7 lock the checker.
    step(1, 8'd5, 0, 0);  chk_all("seed5", 0, 0, 0, 0, 8'd6);
    step(1, 8'd6, 0, 0);  chk_all("sync6", 0, 0, 0, 0, 8'd7);
    step(1, 8'd7, 0, 0);  chk_all("lock7", 1, 0, 0, 0, 8'd8);

    // Value error while locked, then relock.
    step(1, 8'd10, 0, 0); chk_all("err10", 0, 1, 0, 8'd1, 8'd11);
    step(0, 8'd0, 0, 0);  chk_all("errgap", 0, 0, 0, 8'd1, 8'd11);
    step(1, 8'd11, 0, 0); chk_all("sync11", 0, 0, 0, 8'd1, 8'd12);
    step(1, 8'd12, 0, 0); chk_all("relock12", 1, 0, 0, 8'd1, 8'd13);

    // Enable low for 10 cycles with junk on the bus: nothing moves.
    for (int i = 0; i < 10; i++) begin
      step(0, 8'(i * 37), i[0], 0);
    end
    chk_all("gap", 1, 0, 0, 8'd1, 8'd13);
    step(1, 8'd13, 0, 0); chk_all("aftergap13", 1, 0, 0, 8'd1, 8'd14);

    // Carry-only error: value right, cin asserted on a non-max value.
    step(1, 8'd14, 1, 0); chk_all("carry14", 0, 1, 0, 8'd2, 8'd15);

    // Relock just below max, then wrap through 255 -> 0.
    step(1, 8'd252, 0, 0); chk_all("reseed252", 0, 0, 0, 8'd2, 8'd253);
    step(1, 8'd253, 0, 0); chk_all("sync253", 0, 0, 0, 8'd2, 8'd254);
    step(1, 8'd254, 0, 0); chk_all("lock254", 1, 0, 0, 8'd2, 8'd255);
    step(1, 8'd255, 1, 0); chk_all("max255", 1, 0, 0, 8'd2, 8'd0);
    step(1, 8'd0, 0, 0);   chk_all("wrap0", 1, 0, 1, 8'd2, 8'd1);
    step(0, 8'd0, 0, 0);   chk_all("wrapgap", 1, 0, 0, 8'd2, 8'd1);

    // Max value without carry is an error.
    step(1, 8'd252, 0, 0); chk_all("err252", 0, 1, 0, 8'd3, 8'd253);
    step(1, 8'd253, 0, 0); chk_all("sync253b", 0, 0, 0, 8'd3, 8'd254);
    step(1, 8'd254, 0, 0); chk_all("lock254b", 1, 0, 0, 8'd3, 8'd255);
    step(1, 8'd255, 0, 0); chk_all("nocarry255", 0, 1, 0, 8'd4, 8'd0);

    // Drive 300 more locked errors; count must stop at 255.
    for (int i = 0; i < 300; i++) begin
      step(1, 8'd100, 0, 0);
      step(1, 8'd101, 0, 0);
      step(1, 8'd102, 0, 0);
      step(1, 8'd200, 0, 0);
    end
    chk_all("saturate", 0, 1, 0, 8'd255, 8'd201);

    // Clear coincident with an error: count clears, strobe still fires.
    step(1, 8'd100, 0, 0);
    step(1, 8'd101, 0, 0);
    step(1, 8'd102, 0, 0); chk_all("lockclr", 1, 0, 0, 8'd255, 8'd103);
    step(1, 8'd200, 0, 1); chk_all("errclr", 0, 1, 0, 8'd0, 8'd201);
    step(0, 8'd0, 0, 0);   chk_all("postclr", 0, 0, 0, 8'd0, 8'd201);

    // Clear alone leaves state and expected untouched.
    step(1, 8'd100, 0, 0);
    step(1, 8'd101, 0, 0);
    step(1, 8'd102, 0, 0);
    step(1, 8'd200, 0, 0); chk_all("err1", 0, 1, 0, 8'd1, 8'd201);
    step(1, 8'd201, 0, 0); chk_all("sync201", 0, 0, 0, 8'd1, 8'd202);
    step(0, 8'd0, 0, 1);   chk_all("clearonly", 0, 0, 0, 8'd0, 8'd202);
    step(1, 8'd202, 0, 0); chk_all("lock202", 1, 0, 0, 8'd0, 8'd203);

    // Asynchronous reset mid-lock, away from any clock edge.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("asyncrst", 0, 0, 0, 8'd0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 8'd50, 0, 0); chk_all("reseed50", 0, 0, 0, 8'd0, 8'd51);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
